// File: rtl/glitch_detector.sv
// Lockstep comparator for two redundant cores: aligns Core A to Core B's skewed
// timeline, flags divergences and drives an alarm / fatal escalation FSM.
module glitch_detector #(
  parameter int BIT_LENGTH = 32,
  parameter int SKEW       = 2,
  parameter int ERR_LIMIT  = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [BIT_LENGTH-1:0] in_a,
  input  logic                  valid_a,
  input  logic [BIT_LENGTH-1:0] in_b,
  input  logic                  valid_b,
  input  logic                  clear,
  output logic                  mismatch,
  output logic                  alarm,
  output logic                  fatal,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [BIT_LENGTH-1:0] snap_a,
  output logic [BIT_LENGTH-1:0] snap_b
);

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    ALARM   = 2'd1,
    FATAL   = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] LIMIT     = CNT_WIDTH'(ERR_LIMIT);
  localparam logic [2:0]           WARM_INIT = 3'(SKEW);

  logic                  dvalid_a;
  logic [BIT_LENGTH-1:0] din_a;

  state_e                state_q;
  state_e                state_d;
  logic [CNT_WIDTH-1:0]  count_d;
  logic [CNT_WIDTH-1:0]  count_inc;
  logic [BIT_LENGTH-1:0] snap_a_d;
  logic [BIT_LENGTH-1:0] snap_b_d;
  logic                  escalate;

  logic       enable_q;
  logic [2:0] warm_q;
  logic [2:0] warm_eff;
  logic       compare_active;
  logic       diverge;

  // Core A delay line; stage valids are flushed whenever comparison is disabled
  generate
    if (SKEW == 0) begin : g_direct
      assign dvalid_a = valid_a;
      assign din_a    = in_a;
    end else begin : g_delay
      logic [SKEW-1:0]       line_v;
      logic [BIT_LENGTH-1:0] line_d [SKEW];

      always_ff @(posedge clk) begin
        if (!reset || !enable) begin
          line_v <= '0;
        end else begin
          line_v[0] <= valid_a;
          for (int i = 1; i < SKEW; i++) begin
            line_v[i] <= line_v[i-1];
          end
        end
        line_d[0] <= in_a;
        for (int i = 1; i < SKEW; i++) begin
          line_d[i] <= line_d[i-1];
        end
      end

      assign dvalid_a = line_v[SKEW-1];
      assign din_a    = line_d[SKEW-1];
    end
  endgenerate

  // Warm-up reloads on the enable rising edge so the empty delay line is never compared
  always_comb begin
    warm_eff       = (enable && !enable_q) ? WARM_INIT : warm_q;
    compare_active = enable && (warm_eff == 3'd0);
    diverge        = compare_active &&
                     ((dvalid_a != valid_b) ||
                      (dvalid_a && valid_b && (din_a != in_b)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enable_q <= 1'b0;
      warm_q   <= WARM_INIT;
    end else begin
      enable_q <= enable;
      if (enable) begin
        warm_q <= (warm_eff == 3'd0) ? 3'd0 : warm_eff - 3'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = err_count;
    snap_a_d  = snap_a;
    snap_b_d  = snap_b;
    count_inc = (err_count == CNT_MAX) ? CNT_MAX : err_count + CNT_WIDTH'(1);
    escalate  = (count_inc >= LIMIT);

    if (diverge) begin
      count_d = count_inc;
    end

    case (state_q)
      MONITOR: begin
        if (diverge) begin
          state_d  = escalate ? FATAL : ALARM;
          snap_a_d = din_a;
          snap_b_d = in_b;
        end
      end
      // A divergence in the same cycle as clear keeps the alarm raised
      ALARM: begin
        if (diverge) begin
          state_d = escalate ? FATAL : ALARM;
        end else if (clear) begin
          state_d = MONITOR;
        end
      end
      FATAL: begin
        state_d = FATAL;
      end
      default: begin
        state_d = MONITOR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MONITOR;
      mismatch  <= 1'b0;
      alarm     <= 1'b0;
      fatal     <= 1'b0;
      err_count <= '0;
      snap_a    <= '0;
      snap_b    <= '0;
    end else begin
      state_q   <= state_d;
      mismatch  <= diverge;
      alarm     <= (state_d != MONITOR);
      fatal     <= (state_d == FATAL);
      err_count <= count_d;
      snap_a    <= snap_a_d;
      snap_b    <= snap_b_d;
    end
  end

endmodule

// File: tb/tb_glitch_detector.sv
// Directed self-checking bench for glitch_detector (SKEW=2, ERR_LIMIT=3).
module tb_glitch_detector;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] in_a;
  logic        valid_a;
  logic [31:0] in_b;
  logic        valid_b;
  logic        clear;
  logic        mismatch;
  logic        alarm;
  logic        fatal;
  logic [7:0]  err_count;
  logic [31:0] snap_a;
  logic [31:0] snap_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] a_hist [2];
  logic        va_hist [2];

  glitch_detector #(
    .BIT_LENGTH(32),
    .SKEW      (2),
    .ERR_LIMIT (3),
    .CNT_WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_a     (in_a),
    .valid_a  (valid_a),
    .in_b     (in_b),
    .valid_b  (valid_b),
    .clear    (clear),
    .mismatch (mismatch),
    .alarm    (alarm),
    .fatal    (fatal),
    .err_count(err_count),
    .snap_a   (snap_a),
    .snap_b   (snap_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle; outputs are sampled 1 time unit after the capturing edge
  task automatic applyStimulus(input logic [31:0] a, input logic va, input logic [31:0] b,
                               input logic vb, input logic en, input logic clr);
    in_a    = a;
    valid_a = va;
    in_b    = b;
    valid_b = vb;
    enable  = en;
    clear   = clr;
    a_hist[1]  = a_hist[0];
    va_hist[1] = va_hist[0];
    a_hist[0]  = a;
    va_hist[0] = va & en;
    @(posedge clk);
    #1;
  endtask

  task automatic sendMatched(input logic [31:0] a, input logic [31:0] flip, input logic clr);
    applyStimulus(a, 1'b1, a_hist[1] ^ flip, va_hist[1], 1'b1, clr);
  endtask

  task automatic applyReset();
    reset   = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    a_hist[0] = '0;  a_hist[1] = '0;
    va_hist[0] = 1'b0; va_hist[1] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_mismatch"}, {31'd0, mismatch}, 32'd0);
    checkOutput({phase, "_alarm"},    {31'd0, alarm},    32'd0);
    checkOutput({phase, "_fatal"},    {31'd0, fatal},    32'd0);
    checkOutput({phase, "_err"},      {24'd0, err_count}, 32'd0);
    checkOutput({phase, "_snap_a"},   snap_a, 32'd0);
    checkOutput({phase, "_snap_b"},   snap_b, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clk  = 1'b0;
    in_a = '0;
    in_b = '0;
    applyReset();
    applyReset();
    checkResetValues("reset");

    // Clean lockstep stream
    for (int i = 0; i < 100; i++) begin
      sendMatched($urandom, 32'd0, 1'b0);
      checkOutput("clean_mm", {31'd0, mismatch}, 32'd0);
    end
    checkOutput("clean_err",   {24'd0, err_count}, 32'd0);
    checkOutput("clean_alarm", {31'd0, alarm}, 32'd0);

    // Single bit flip
    sendMatched(32'h0000_00A5, 32'd0, 1'b0);
    sendMatched(32'h0000_0011, 32'd0, 1'b0);
    sendMatched(32'h0000_0022, 32'd1, 1'b0);
    checkOutput("flip_mm",     {31'd0, mismatch}, 32'd1);
    checkOutput("flip_alarm",  {31'd0, alarm}, 32'd1);
    checkOutput("flip_fatal",  {31'd0, fatal}, 32'd0);
    checkOutput("flip_err",    {24'd0, err_count}, 32'd1);
    checkOutput("flip_snap_a", snap_a, 32'h0000_00A5);
    checkOutput("flip_snap_b", snap_b, 32'h0000_00A4);

    // Clear together with divergence
    sendMatched(32'h0000_0033, 32'h0000_0100, 1'b1);
    checkOutput("clrdiv_mm",     {31'd0, mismatch}, 32'd1);
    checkOutput("clrdiv_alarm",  {31'd0, alarm}, 32'd1);
    checkOutput("clrdiv_err",    {24'd0, err_count}, 32'd2);
    checkOutput("clrdiv_snap_a", snap_a, 32'h0000_00A5);

    // Clean clear
    sendMatched(32'h0000_0044, 32'd0, 1'b1);
    checkOutput("clr_mm",    {31'd0, mismatch}, 32'd0);
    checkOutput("clr_alarm", {31'd0, alarm}, 32'd0);
    checkOutput("clr_err",   {24'd0, err_count}, 32'd2);

    // Third divergence escalates from MONITOR
    sendMatched(32'h0000_0055, 32'h8000_0000, 1'b0);
    checkOutput("esc_fatal",  {31'd0, fatal}, 32'd1);
    checkOutput("esc_alarm",  {31'd0, alarm}, 32'd1);
    checkOutput("esc_err",    {24'd0, err_count}, 32'd3);
    checkOutput("esc_snap_a", snap_a, 32'h0000_0033);
    checkOutput("esc_snap_b", snap_b, 32'h8000_0033);

    sendMatched(32'h0000_0066, 32'd0, 1'b1);
    checkOutput("fatal_clr_alarm", {31'd0, alarm}, 32'd1);
    checkOutput("fatal_clr_fatal", {31'd0, fatal}, 32'd1);
    checkOutput("fatal_clr_mm",    {31'd0, mismatch}, 32'd0);

    sendMatched(32'h0000_0077, 32'h0000_00F0, 1'b0);
    checkOutput("fatal_div_mm",     {31'd0, mismatch}, 32'd1);
    checkOutput("fatal_div_err",    {24'd0, err_count}, 32'd4);
    checkOutput("fatal_div_snap_a", snap_a, 32'h0000_0033);

    applyReset();
    checkResetValues("rst_fatal");

    // Warm-up after enable rise, then valid-qualifier cases
    applyStimulus(32'h10, 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
    checkOutput("warm1_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'h20, 1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b0);
    checkOutput("warm2_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'h30, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    checkOutput("warm3_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'h40, 1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
    checkOutput("resume_mm",    {31'd0, mismatch}, 32'd1);
    checkOutput("resume_err",   {24'd0, err_count}, 32'd1);
    checkOutput("resume_snap_a", snap_a, 32'h20);
    applyStimulus(32'h50, 1'b1, 32'h30, 1'b1, 1'b1, 1'b1);
    checkOutput("resume_clr_alarm", {31'd0, alarm}, 32'd0);
    applyStimulus(32'h60, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0);
    checkOutput("vq_a_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'h70, 1'b1, 32'h50, 1'b1, 1'b1, 1'b0);
    checkOutput("vq_b_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'h80, 1'b1, 32'h60, 1'b1, 1'b1, 1'b0);
    checkOutput("vq_div_mm",     {31'd0, mismatch}, 32'd1);
    checkOutput("vq_div_err",    {24'd0, err_count}, 32'd2);
    checkOutput("vq_div_alarm",  {31'd0, alarm}, 32'd1);
    checkOutput("vq_div_snap_a", snap_a, 32'h60);
    checkOutput("vq_div_snap_b", snap_b, 32'h60);
    applyStimulus(32'h90, 1'b0, 32'h70, 1'b1, 1'b1, 1'b1);
    checkOutput("vq_clr_alarm", {31'd0, alarm}, 32'd0);
    applyStimulus(32'hA0, 1'b0, 32'h80, 1'b1, 1'b1, 1'b0);
    checkOutput("vq_c_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'hB0, 1'b1, 32'hFFFF, 1'b0, 1'b1, 1'b0);
    checkOutput("both_low1_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'hC0, 1'b1, 32'h5555, 1'b0, 1'b1, 1'b0);
    checkOutput("both_low2_mm", {31'd0, mismatch}, 32'd0);
    checkOutput("both_low_err", {24'd0, err_count}, 32'd2);

    // Disabled cycle holds everything, then re-enable warm-up
    applyStimulus(32'h1, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    checkOutput("dis_mm",    {31'd0, mismatch}, 32'd0);
    checkOutput("dis_err",   {24'd0, err_count}, 32'd2);
    checkOutput("dis_alarm", {31'd0, alarm}, 32'd0);
    applyStimulus(32'hD0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b0);
    checkOutput("reen1_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'hE0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0);
    checkOutput("reen2_mm", {31'd0, mismatch}, 32'd0);
    applyStimulus(32'hF0, 1'b1, 32'hD0, 1'b1, 1'b1, 1'b0);
    checkOutput("reen3_mm",  {31'd0, mismatch}, 32'd0);
    checkOutput("reen3_err", {24'd0, err_count}, 32'd2);
    applyStimulus(32'h100, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("vq_esc_mm",    {31'd0, mismatch}, 32'd1);
    checkOutput("vq_esc_err",   {24'd0, err_count}, 32'd3);
    checkOutput("vq_esc_fatal", {31'd0, fatal}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
